// File: rtl/fifo_param.sv
// Synchronous FIFO with a DEPTH-entry circular buffer, registered read data,
// programmable almost-full/almost-empty thresholds, and overflow/underflow pulses.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic push_ok;
    logic pop_ok;
    logic push_drop;
    logic pop_reject;

    // Handshake: push and pop are single-cycle requests sampled on the rising
    // edge. A pop is taken only when the FIFO holds data; a push is taken when
    // there is room or when a pop frees a slot in the same cycle. A pop into an
    // empty FIFO never reads the word being pushed alongside it.
    always_comb begin
        pop_ok     = pop && !fifo_empty;
        push_ok    = push && (!fifo_full || pop);
        push_drop  = push && fifo_full && !pop;
        pop_reject = pop && fifo_empty;
    end

    // Flags follow the registered count, so they move on the same edge as it
    // and collapse to their reset values as soon as reset pulls count to zero.
    always_comb begin
        fifo_full    = (count == DEPTH_CNT);
        fifo_empty   = (count == '0);
        almost_full  = (count >= AF_CNT);
        almost_empty = (count <= AE_CNT);
    end

    // Storage has no reset; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            overflow  <= push_drop;
            underflow <= pop_reject;

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            // On a simultaneous push at full, wr_ptr == rd_ptr; the read sees
            // the old head because the memory write lands on the same edge.
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end

            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
// directed scenarios followed by a random run, checked against a queue model.
module tb_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk;
    logic             reset;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [2:0]       count;
    logic             overflow;
    logic             underflow;

    fifo_param #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the FIFO contents as an ordered queue of words
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_udf;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".count"},        32'(count),        32'(n));
        check({tag, ".full"},         32'(fifo_full),    32'(n == DEPTH));
        check({tag, ".empty"},        32'(fifo_empty),   32'(n == 0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({tag, ".data_out"},     32'(data_out),     32'(exp_data));
        check({tag, ".valid_out"},    32'(valid_out),    32'(exp_valid));
        check({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(exp_udf));
    endtask

    // Driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic cycle(input string tag, input logic c, input logic pu,
                         input logic po, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        clear   = c;
        push    = pu;
        pop     = po;
        data_in = d;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (c) begin
            exp_q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
        end else begin
            exp_valid = po && !was_empty;
            if (exp_valid) exp_data = exp_q.pop_front();
            if (pu && (!was_full || po)) exp_q.push_back(d);
            exp_ovf = pu && was_full && !po;
            exp_udf = po && was_empty;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;

        #12;
        check_all("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Fill and drain in order
        cycle("fill0", 0, 1, 0, 8'd5);
        cycle("fill1", 0, 1, 0, 8'd9);
        cycle("fill2", 0, 1, 0, 8'd7);
        cycle("fill3", 0, 1, 0, 8'd45);
        for (int i = 0; i < 4; i++) cycle("drain", 0, 0, 1, '0);
        idle("drain_idle");

        // Overflow at full
        for (int i = 0; i < 4; i++) cycle("ovf_fill", 0, 1, 0, 8'(10 + i));
        cycle("ovf_push", 0, 1, 0, 8'd100);
        idle("ovf_idle");
        for (int i = 0; i < 4; i++) cycle("ovf_drain", 0, 0, 1, '0);

        // Push and pop together at full
        for (int i = 0; i < 4; i++) cycle("pp_fill", 0, 1, 0, 8'(20 + i));
        cycle("pp_both", 0, 1, 1, 8'd77);
        for (int i = 0; i < 4; i++) cycle("pp_drain", 0, 0, 1, '0);

        // Underflow cases
        cycle("udf_pop", 0, 0, 1, '0);
        cycle("udf_pushpop", 0, 1, 1, 8'd3);
        cycle("udf_next", 0, 0, 1, '0);

        // Pointer wrap with interleaved pops
        cycle("wrap_a", 0, 1, 0, 8'd31);
        cycle("wrap_b", 0, 1, 0, 8'd32);
        cycle("wrap_c", 0, 1, 0, 8'd33);
        cycle("wrap_p0", 0, 0, 1, '0);
        cycle("wrap_p1", 0, 0, 1, '0);
        cycle("wrap_d", 0, 1, 0, 8'd34);
        cycle("wrap_e", 0, 1, 0, 8'd35);
        cycle("wrap_f", 0, 1, 0, 8'd36);
        for (int i = 0; i < 4; i++) cycle("wrap_drain", 0, 0, 1, '0);

        // Asynchronous reset mid-cycle with 3 entries stored
        for (int i = 0; i < 3; i++) cycle("ar_fill", 0, 1, 0, 8'(50 + i));
        cycle("ar_pop", 0, 0, 1, '0);
        cycle("ar_refill", 0, 1, 0, 8'd60);
        #3 reset = 1'b0;
        exp_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        #1 check_all("async_reset");
        #1 reset = 1'b1;
        idle("post_reset");
        cycle("post_reset_push", 0, 1, 0, 8'd88);
        cycle("post_reset_pop", 0, 0, 1, '0);

        // Clear wins over push
        cycle("clr_fill0", 0, 1, 0, 8'd1);
        cycle("clr_fill1", 0, 1, 0, 8'd2);
        cycle("clr_push", 1, 1, 0, 8'd99);
        cycle("clr_pop", 0, 0, 1, '0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries, power of two, minimum 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full asserts at count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty asserts at count <= AE_LEVEL.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports clk and reset.
REQ-006 SHALL have port: clk  input  1  rising-edge clock.
REQ-007 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-008 SHALL have port: clear  input  1  synchronous flush.
REQ-009 SHALL have port: push  input  1  write request.
REQ-010 SHALL have port: pop  input  1  read request.
REQ-011 SHALL have port: data_in  input  WIDTH  write data.
REQ-012 SHALL have port: data_out  output  WIDTH  registered read data.
REQ-013 SHALL have port: valid_out  output  1  one-cycle pulse when data_out is loaded.
REQ-014 SHALL have port: fifo_full  output  1  count == DEPTH.
REQ-015 SHALL have port: fifo_empty  output  1  count == 0.
REQ-016 SHALL have port: almost_full  output  1  count >= AF_LEVEL.
REQ-017 SHALL have port: almost_empty  output  1  count <= AE_LEVEL.
REQ-018 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 SHALL have port: overflow  output  1  one-cycle pulse when a push is dropped.
REQ-020 SHALL have port: underflow  output  1  one-cycle pulse when a pop is rejected.

Function
REQ-021 SHALL store words in a DEPTH-entry circular buffer, using write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-022 SHALL accept a push when fifo_full=0, or when fifo_full=1 and pop=1 in the same cycle; an accepted push writes data_in at wr_ptr and increments wr_ptr.
REQ-023 SHALL accept a pop when fifo_empty=0; an accepted pop loads data_out with the head entry at the next rising edge and increments rd_ptr.
REQ-024 SHALL pulse valid_out high for exactly the cycle after each accepted pop; data_out SHALL hold its value in all other cycles.
REQ-025 SHALL, on push and pop accepted together, leave count unchanged; when full, the popped word is the old head, never the incoming word.
REQ-026 SHALL reject a pop while empty even if push=1 in the same cycle, with no write-through; the push is accepted and underflow pulses.
REQ-027 SHALL, on push with fifo_full=1 and pop=0, drop the write, leave the pointers and count unchanged, and pulse overflow for one cycle.
REQ-028 SHALL, on pop with fifo_empty=1, leave data_out and the pointers unchanged and pulse underflow for one cycle.
REQ-029 SHALL update count, fifo_full, fifo_empty, almost_full and almost_empty in the same clock edge as the push or pop that changes occupancy, so all flags are registered or derived from registered count.
REQ-030 SHALL give clear=1 priority over push and pop: pointers and count go to 0, data_out goes to 0, valid_out, overflow and underflow go to 0, and memory contents are don't-care.
REQ-031 SHALL keep count in the range 0..DEPTH under all input combinations.

Reset
REQ-032 SHALL, while reset=0, immediately (without a clock edge) force the pointers and count to 0, data_out to 0, valid_out, overflow and underflow to 0, fifo_empty to 1, almost_empty to 1, fifo_full to 0, and almost_full to 0.
REQ-033 SHALL discard all stored words when reset is asserted mid-operation, and SHALL begin normal operation on the first rising edge after reset returns to 1.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-034 SHALL verify this sequence: push 5, 9, 7, 45 on consecutive cycles -> count goes 1,2,3,4; almost_full rises at count 3; fifo_full rises at count 4; then pop x4 -> data_out 5, 9, 7, 45 with valid_out pulses, and fifo_empty returns to 1.
REQ-035 SHALL verify this sequence: fill to 4 entries, then push 100 with pop=0 -> overflow pulses once and count stays 4; subsequent pops return the original 4 words and never 100.
REQ-036 SHALL verify this sequence: at full, push 77 and pop together -> data_out is the old head, count stays 4, and 77 is read last after draining.
REQ-037 SHALL verify this sequence: while empty, pop alone -> underflow pulses and data_out holds; while empty, push 3 and pop together -> count becomes 1, underflow pulses, and the next pop returns 3.
REQ-038 SHALL verify this sequence: write 6 words with 2 interleaved pops to exercise pointer wrap -> output order matches input order exactly.
REQ-039 SHALL verify this sequence: with 3 entries stored, assert reset=0 asynchronously mid-cycle -> outputs reach reset values before the next edge; separately, clear=1 together with push=1 -> count 0 and fifo_empty 1.
